// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR engine sharing one MAC across all taps
// Define FIR_SAT_EN to clamp results to DOUT_W and flag sat; otherwise results wrap.
module fir_mac_sequencer #(
   parameter int TAPS   = 16,
   parameter int DIN_W  = 16,
   parameter int COEF_W = 16,
   parameter int DOUT_W = 16,
   parameter int SHIFT  = 15
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]        coef_wdata,
   input  logic                     flush,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DIN_W-1:0]         s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DOUT_W-1:0]        m_data,
   output logic                     busy,
   output logic                     sat
);
   localparam int AW     = $clog2(TAPS);
   localparam int PW     = DIN_W + COEF_W;
   localparam int ACC_W  = PW + AW;
   localparam int CDEPTH = 2 ** AW;
   localparam logic [AW-1:0] LAST    = AW'(TAPS - 1);
   localparam logic [AW-1:0] TAPS_AW = AW'(TAPS);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state, state_nxt;

   logic signed [DIN_W-1:0]  dline [TAPS];
   logic signed [COEF_W-1:0] coef  [CDEPTH];
   logic [AW-1:0]            wr_ptr, k, rd_idx;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc, acc_nxt;
   logic [DOUT_W-1:0]        dout_val;
   logic                     s_ready_r;
   logic                     accept, last_tap;

   assign s_ready  = s_ready_r & ~flush;
   assign busy     = (state != IDLE);
   assign accept   = (state == IDLE) & s_valid & s_ready;
   assign last_tap = (k == LAST);

   // Newest sample sits at wr_ptr; tap k reaches k samples back, wrapping through TAPS-1.
   always_comb begin
      rd_idx  = (wr_ptr >= k) ? wr_ptr - k : wr_ptr - k + TAPS_AW;
      prod    = coef[k] * dline[rd_idx];
      acc_nxt = acc + {{AW{prod[PW-1]}}, prod};
   end

`ifdef FIR_SAT_EN
   logic signed [ACC_W-1:0] shifted;
   logic                    dout_sat;

   // Fits in DOUT_W only when every bit from the DOUT_W sign bit upward agrees.
   always_comb begin
      shifted  = acc_nxt >>> SHIFT;
      dout_sat = !((&shifted[ACC_W-1:DOUT_W-1]) || !(|shifted[ACC_W-1:DOUT_W-1]));
      dout_val = dout_sat ? {shifted[ACC_W-1], {(DOUT_W-1){~shifted[ACC_W-1]}}}
                          : shifted[DOUT_W-1:0];
   end
`else
   always_comb dout_val = DOUT_W'(acc_nxt >>> SHIFT);
   assign sat = 1'b0;
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = MAC;
         MAC:     if (last_tap) state_nxt = OUT;
         OUT:     if (m_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr    <= '0;
         k         <= '0;
         acc       <= '0;
         s_ready_r <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
`ifdef FIR_SAT_EN
         sat       <= 1'b0;
`endif
         for (int i = 0; i < TAPS; i++)   dline[i] <= '0;
         for (int i = 0; i < CDEPTH; i++) coef[i]  <= '0;
      end else begin
         s_ready_r <= (state_nxt == IDLE);
         if (coef_we) coef[coef_addr] <= coef_wdata;
         case (state)
            IDLE: begin
               if (flush) begin
                  for (int i = 0; i < TAPS; i++) dline[i] <= '0;
                  wr_ptr <= '0;
               end else if (accept) begin
                  dline[wr_ptr] <= s_data;
                  acc           <= '0;
                  k             <= '0;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               k   <= k + 1'b1;
               if (last_tap) begin
                  m_valid <= 1'b1;
                  m_data  <= dout_val;
`ifdef FIR_SAT_EN
                  sat     <= dout_sat;
`endif
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  wr_ptr  <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
`ifdef FIR_SAT_EN
                  sat     <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench for fir_mac_sequencer (TAPS=4, SHIFT=0)
// Honours FIR_SAT_EN the same way the design does.
module tb_fir_mac_sequencer;
   localparam int TAPS  = 4;
   localparam int SHIFT = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        coef_we;
   logic [1:0]  coef_addr;
   logic [15:0] coef_wdata;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        busy;
   logic        sat;

   fir_mac_sequencer #(
      .TAPS(TAPS), .DIN_W(16), .COEF_W(16), .DOUT_W(16), .SHIFT(SHIFT)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .busy(busy), .sat(sat)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: sample history newest-first, coefficient table, queue of pending results.
   int          hist  [TAPS];
   int          mcoef [TAPS];
   logic [16:0] exp_q [$];
   logic [16:0] got   [$];
   bit          pend, fresh, exp_sready, exp_mvalid;
   int          t_acc;

   function automatic logic [16:0] model_out();
      longint acc = 0;
      for (int i = 0; i < TAPS; i++) acc += longint'(mcoef[i]) * longint'(hist[i]);
      acc = acc >>> SHIFT;
`ifdef FIR_SAT_EN
      if (acc > 32767)  return {1'b1, 16'h7FFF};
      if (acc < -32768) return {1'b1, 16'h8000};
`endif
      return {1'b0, acc[15:0]};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_s_ready", s_ready, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_sat", sat, 0);
         pend  = 0;
         fresh = 1;
         exp_q.delete();
         got.delete();
         for (int i = 0; i < TAPS; i++) begin hist[i] = 0; mcoef[i] = 0; end
      end else begin
         exp_sready = !pend && !fresh && !flush;
         exp_mvalid = pend && (cyc >= t_acc + TAPS);
         chk("s_ready", s_ready, exp_sready);
         chk("busy", busy, pend);
         chk("m_valid", m_valid, exp_mvalid);
         if (exp_mvalid && exp_q.size() > 0) begin
            chk("m_data", m_data, exp_q[0][15:0]);
            chk("sat", sat, exp_q[0][16]);
         end
         if (coef_we) mcoef[coef_addr] = int'($signed(coef_wdata));
         if (exp_mvalid && m_ready) begin
            pend = 0;
            got.push_back({sat, m_data});
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end else if (!pend) begin
            if (flush) begin
               for (int i = 0; i < TAPS; i++) hist[i] = 0;
            end else if (s_valid && exp_sready) begin
               for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
               hist[0] = int'($signed(s_data));
               exp_q.push_back(model_out());
               pend  = 1;
               t_acc = cyc + 1;
            end
         end
         fresh = 0;
      end
   end

   task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
      coef_we = 1'b1; coef_addr = a; coef_wdata = d;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      bit ok = 0;
      s_valid = 1'b1; s_data = d;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!busy && s_ready) begin ok = 1; break; end
      end
      if (!ok) chk("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic expect_out(input string name, input logic s, input logic [15:0] v);
      if (got.size() == 0) chk({name, "_missing"}, 0, 1);
      else begin
         chk(name, got[0][15:0], v);
         chk({name, "_sat"}, got[0][16], s);
         void'(got.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [6:0]  mv, bz, sr;
   logic [15:0] held;
   bit          stable, seen;

   initial begin
      rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Impulse response
      write_coef(2'd0, 16'd1); write_coef(2'd1, 16'd2);
      write_coef(2'd2, 16'd3); write_coef(2'd3, 16'd4);
      send(16'd1); send(16'd0); send(16'd0); send(16'd0); send(16'd0);
      wait_idle();
      expect_out("imp0", 0, 16'd1); expect_out("imp1", 0, 16'd2);
      expect_out("imp2", 0, 16'd3); expect_out("imp3", 0, 16'd4);
      expect_out("imp4", 0, 16'd0);

      // Latency/throughput: bit i = cycle following accept edge + i
      send(16'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); mv[i] = m_valid; bz[i] = busy; sr[i] = s_ready;
      end
      chk("lat_m_valid", mv, 7'b0010000);
      chk("lat_busy", bz, 7'b0011111);
      chk("lat_s_ready", sr, 7'b1100000);
      wait_idle();
      expect_out("lat_out", 0, 16'd0);

      // Backpressure
      m_ready = 1'b0;
      send(16'd9);
      seen = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (m_valid) begin seen = 1; break; end
      end
      chk("bp_valid_seen", seen, 1);
      held = m_data; stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_data !== held || s_ready !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b1) stable = 0;
      end
      chk("bp_stable", stable, 1);
      chk("bp_data", held, 16'd9);
      @(posedge clk); #1 m_ready = 1'b1;
      @(posedge clk); #1 m_ready = 1'b0;
      @(negedge clk);
      chk("bp_s_ready_back", s_ready, 1);
      chk("bp_m_valid_low", m_valid, 0);
      m_ready = 1'b1;
      @(posedge clk); #1;
      expect_out("bp_out", 0, 16'd9);

      // Flush beats a simultaneous sample, then impulse shows no residue
      send(16'd5); send(16'd5); send(16'd5);
      wait_idle();
      got.delete();
      flush = 1'b1; s_valid = 1'b1; s_data = 16'd99;
      @(negedge clk);
      chk("flush_s_ready", s_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      chk("flush_no_accept", busy, 0);
      @(posedge clk); #1;
      send(16'd1); send(16'd0); send(16'd0); send(16'd0);
      wait_idle();
      expect_out("fl0", 0, 16'd1); expect_out("fl1", 0, 16'd2);
      expect_out("fl2", 0, 16'd3); expect_out("fl3", 0, 16'd4);
      chk("flush_extra", got.size(), 0);

      // Saturation / wrap
      for (int i = 0; i < 4; i++) write_coef(2'(i), 16'h7FFF);
      for (int i = 0; i < 4; i++) send(16'h7FFF);
      wait_idle();
      got.delete();
      // 4th result was the last popped; recompute by re-observing via the model queue is not needed:
      // resend the same history once more (history already all 0x7FFF) for a literal check.
      send(16'h7FFF);
      wait_idle();
`ifdef FIR_SAT_EN
      expect_out("sat4", 1, 16'h7FFF);
`else
      expect_out("wrap4", 0, 16'h0004);
`endif

      // Reset in the second MAC cycle
      send(16'd7);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      send(16'd7);
      wait_idle();
      expect_out("post_rst", 0, 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR engine for the fir_ip AXI4-Lite peripheral. It accepts one input sample on a valid/ready stream and holds the sample history in an internal circular delay line. A state machine sequences a single shared multiply-accumulate unit across all taps. Each result is emitted on a valid/ready output stream. Coefficients are loaded through a simple write port driven by the IP's AXI4-Lite slave register decode.

## Interface
- TAPS, 16: number of taps, 2..64.
- DIN_W, 16: signed input sample width.
- COEF_W, 16: signed coefficient width.
- DOUT_W, 16: signed output width.
- SHIFT, 15: arithmetic right shift applied to the accumulator before output, 0..DIN_W+COEF_W-1.
- Derived, not overridable:
  - AW = clog2(TAPS).
  - ACC_W = DIN_W+COEF_W+AW.

Ports:
- ACLK  in  1  sole clock, rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index; 0 multiplies the newest sample.
- coef_wdata  in  COEF_W  signed coefficient.
- flush  in  1  clear the delay line.
- s_valid  in  1  input sample valid.
- s_ready  out  1  engine can accept a sample.
- s_data  in  DIN_W  signed input sample.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  DOUT_W  signed result.
- busy  out  1  state is not IDLE.
- sat  out  1  high with m_valid when the result was clamped.

## Operation
- States:
  - IDLE: waiting for a sample.
  - MAC: TAPS cycles, one tap per cycle.
  - OUT: holding the result until m_ready.
- Reset values (asynchronous):
  - State IDLE; wr_ptr 0; tap counter k 0; acc 0.
  - Delay line all 0; coefficients all 0.
  - s_ready 0, m_valid 0, m_data 0, busy 0, sat 0.
- s_ready is registered. It is 1 in IDLE from the first ACLK edge after ARESETN deasserts, and 0 in any cycle where flush=1.
- IDLE:
  - flush=1: delay line cleared to 0 and wr_ptr set to 0 at the edge; no sample accepted. Flush wins over a simultaneous s_valid.
  - s_valid & s_ready: s_data written to buf[wr_ptr]; acc←0, k←0; go to MAC.
- MAC:
  - Each edge: acc += coef[k] * buf[(wr_ptr − k) mod TAPS]; k←k+1.
  - The modulo wraps through TAPS−1 at wr_ptr=0; buf index is wr_ptr − k wrapped to 0..TAPS−1.
  - At k=TAPS−1 the final product is added, state goes to OUT, and m_valid←1.
- OUT:
  - m_data is derived from acc and held stable while m_valid=1.
  - On m_valid & m_ready: m_valid←0, wr_ptr←(wr_ptr+1) mod TAPS, state goes to IDLE.
- flush outside IDLE is ignored. A held flush takes effect on the first IDLE cycle.
- Coefficient writes are accepted in any state and take effect at the edge. A tap uses the value present in its own MAC cycle.
- Arithmetic:
  - Products are full-precision signed DIN_W+COEF_W bits.
  - acc is ACC_W bits wide, so overflow is impossible.
  - Output value = acc >>> SHIFT (arithmetic shift), then narrowed to DOUT_W as described under Configuration.

## Timing
- Sample accepted at edge T.
- MAC edges are T+1..T+TAPS.
- m_valid is high from cycle T+TAPS+1.
- With m_ready held at 1, the result handshake completes at edge T+TAPS+1 and s_ready is 1 again in cycle T+TAPS+2.
- Maximum throughput is 1 sample per TAPS+2 cycles.
- Backpressure: m_valid, m_data and sat stay stable, and s_ready stays 0, until m_ready.
- ARESETN asserted mid-operation returns every output to its reset value immediately. The in-flight result is lost and coefficients are cleared.

## Configuration
- FIR_SAT_EN defined:
  - The shifted value is clamped to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1].
  - sat=1 with m_valid when clamping occurred; sat clears on the handshake.
- FIR_SAT_EN undefined:
  - The low DOUT_W bits of the shifted value are taken (two's-complement wrap).
  - sat is tied to 0.

## Test plan
All scenarios use TAPS=4 and SHIFT=0.
- Impulse: coefficients {1,2,3,4}, inputs 1,0,0,0,0 with m_ready=1 → outputs 1,2,3,4,0; sat always 0.
- Latency and throughput: sample accepted at edge T → m_valid rises in cycle T+5; next s_ready=1 in cycle T+6; busy=1 from cycles T+1 through T+5.
- Backpressure: m_ready=0 for 10 cycles after m_valid → m_data unchanged, s_ready=0, busy=1; a single m_ready pulse completes the transfer and s_ready returns to 1 in the next cycle.
- Flush:
  - Send 5,5,5, then flush=1 together with s_valid=1 → that sample is not accepted.
  - Then impulse 1 with coefficients {1,2,3,4} → outputs 1,2,3,4, with no residue of the 5s.
- Saturation: all coefficients 0x7FFF, inputs 0x7FFF ×4 →
  - with FIR_SAT_EN: fourth output is 0x7FFF with sat=1;
  - without it: fourth output is 0x0004 (low 16 bits of 0xFFFC0004).
- Reset mid-MAC: assert ARESETN in the 2nd MAC cycle → m_valid=0, s_ready=0, busy=0 immediately; after release, input 7 produces output 0 because the coefficients were cleared.
